// File: rtl/settings_pkg.sv
// Shared types and helpers for the clock settings controller: FSM state
// encoding, field width helpers and the button step sizes.
package settings_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EDIT_TIME  = 2'd1,
    EDIT_ALARM = 2'd2
  } state_e;

  localparam int STEP_UNIT = 1;
  localparam int STEP_TENS = 10;

  // Bits needed to hold values 0 .. modulus-1 (never less than one bit).
  function automatic int field_w(input int modulus);
    if (modulus <= 1) begin
      return 1;
    end else begin
      return $clog2(modulus);
    end
  endfunction

  // Bits needed to address count alarm slots (never less than one bit).
  function automatic int sel_w(input int count);
    if (count <= 1) begin
      return 1;
    end else begin
      return $clog2(count);
    end
  endfunction

endpackage

// File: rtl/field_stepper.sv
// Combinational inc/dec step for one time field (minutes or hours).
// Unit steps wrap around the modulus; tens steps saturate (no change when
// the step would leave 0 .. MOD-1). Simultaneous inc and dec cancel.
module field_stepper
  import settings_pkg::*;
#(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic [W-1:0] value,
  input  logic         inc,
  input  logic         dec,
  input  logic         tens,
  output logic [W-1:0] next_value
);

  int value_i;
  assign value_i = int'(value);

  // Next field value from the requested step direction and size.
  always_comb begin
    next_value = value;
    if (inc && !dec) begin
      if (tens) begin
        if (value_i + STEP_TENS < MOD) begin
          next_value = W'(value_i + STEP_TENS);
        end else begin
          next_value = value;
        end
      end else begin
        if (value_i + STEP_UNIT >= MOD) begin
          next_value = {W{1'b0}};
        end else begin
          next_value = W'(value_i + STEP_UNIT);
        end
      end
    end else if (dec && !inc) begin
      if (tens) begin
        if (value_i >= STEP_TENS) begin
          next_value = W'(value_i - STEP_TENS);
        end else begin
          next_value = value;
        end
      end else begin
        if (value_i == 0) begin
          next_value = W'(MOD - 1);
        end else begin
          next_value = W'(value_i - STEP_UNIT);
        end
      end
    end else begin
      next_value = value;
    end
  end

endmodule

// File: rtl/time_settings_ctrl.sv
// Clock settings controller: owns live HH:MM and NUM_ALARMS alarm slots.
// Edits go to a shadow copy, commit on a save_switch rising edge and are
// reverted after TIMEOUT_TICKS idle seconds.
// Optional build macro ALARM_DISABLE_EN adds alarm_disable_btn, which disarms
// the slot being edited.
module time_settings_ctrl
  import settings_pkg::*;
#(
  parameter  int MAX_MINUTES   = 60,
  parameter  int MAX_HOURS     = 24,
  parameter  int NUM_ALARMS    = 4,
  parameter  int TIMEOUT_TICKS = 5,
  localparam int MIN_W         = field_w(MAX_MINUTES),
  localparam int HR_W          = field_w(MAX_HOURS),
  localparam int SEL_W         = sel_w(NUM_ALARMS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick_second,
  input  logic                         tick_minute,
  input  logic                         time_mode_switch,
  input  logic                         alarm_mode_switch,
  input  logic                         save_switch,
  input  logic [SEL_W-1:0]             alarm_sel,
  input  logic                         digit_sel,
  input  logic                         inc_min_btn,
  input  logic                         dec_min_btn,
  input  logic                         inc_hour_btn,
  input  logic                         dec_hour_btn,
`ifdef ALARM_DISABLE_EN
  input  logic                         alarm_disable_btn,
`endif
  output logic [MIN_W-1:0]             current_minutes,
  output logic [HR_W-1:0]              current_hours,
  output logic [MIN_W-1:0]             edit_minutes,
  output logic [HR_W-1:0]              edit_hours,
  output logic [NUM_ALARMS*MIN_W-1:0]  alarm_minutes_flat,
  output logic [NUM_ALARMS*HR_W-1:0]   alarm_hours_flat,
  output logic [NUM_ALARMS-1:0]        alarm_enable,
  output logic                         set_alarm,
  output logic                         editing,
  output logic                         timeout_revert
);

  localparam int CNT_W = field_w(TIMEOUT_TICKS + 1);

  state_e                 state_r;
  logic [MIN_W-1:0]       cur_min_r;
  logic [HR_W-1:0]        cur_hr_r;
  logic [MIN_W-1:0]       ed_min_r;
  logic [HR_W-1:0]        ed_hr_r;
  logic [MIN_W-1:0]       alarm_min_r [NUM_ALARMS];
  logic [HR_W-1:0]        alarm_hr_r  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0]  alarm_en_r;
  logic [SEL_W-1:0]       sel_q_r;
  logic [CNT_W-1:0]       idle_cnt_r;
  logic                   save_q_r;
  logic                   set_alarm_r;
  logic                   timeout_revert_r;
  logic                   editing_r;

  logic [MIN_W-1:0]       min_step_s;
  logic [HR_W-1:0]        hr_step_s;
  logic [MIN_W-1:0]       live_min_next_s;
  logic [HR_W-1:0]        live_hr_next_s;
  logic [MIN_W-1:0]       committed_min_s;
  logic [HR_W-1:0]        committed_hr_s;
  logic                   commit_s;
  logic                   press_s;
  logic                   still_editing_s;

  field_stepper #(.MOD(MAX_MINUTES), .W(MIN_W)) u_min_stepper (
    .value      (ed_min_r),
    .inc        (inc_min_btn),
    .dec        (dec_min_btn),
    .tens       (digit_sel),
    .next_value (min_step_s)
  );

  field_stepper #(.MOD(MAX_HOURS), .W(HR_W)) u_hr_stepper (
    .value      (ed_hr_r),
    .inc        (inc_hour_btn),
    .dec        (dec_hour_btn),
    .tens       (digit_sel),
    .next_value (hr_step_s)
  );

  // Live time one minute ahead, with minute carry into hours and day wrap.
  always_comb begin
    live_min_next_s = cur_min_r;
    live_hr_next_s  = cur_hr_r;
    if (cur_min_r == MIN_W'(MAX_MINUTES - 1)) begin
      live_min_next_s = {MIN_W{1'b0}};
      if (cur_hr_r == HR_W'(MAX_HOURS - 1)) begin
        live_hr_next_s = {HR_W{1'b0}};
      end else begin
        live_hr_next_s = cur_hr_r + HR_W'(1);
      end
    end else begin
      live_min_next_s = cur_min_r + MIN_W'(1);
      live_hr_next_s  = cur_hr_r;
    end
  end

  // Committed value the shadow reverts to, plus edit-state qualifiers.
  always_comb begin
    committed_min_s = cur_min_r;
    committed_hr_s  = cur_hr_r;
    still_editing_s = 1'b0;
    if (state_r == EDIT_ALARM) begin
      committed_min_s = alarm_min_r[sel_q_r];
      committed_hr_s  = alarm_hr_r[sel_q_r];
      still_editing_s = alarm_mode_switch;
    end else if (state_r == EDIT_TIME) begin
      committed_min_s = cur_min_r;
      committed_hr_s  = cur_hr_r;
      still_editing_s = time_mode_switch;
    end else begin
      committed_min_s = cur_min_r;
      committed_hr_s  = cur_hr_r;
      still_editing_s = 1'b0;
    end
  end

  // Any button activity that counts as user input for the idle timer.
  always_comb begin
    press_s = inc_min_btn | dec_min_btn | inc_hour_btn | dec_hour_btn;
`ifdef ALARM_DISABLE_EN
    if (state_r == EDIT_ALARM) begin
      press_s = press_s | alarm_disable_btn;
    end else begin
      press_s = press_s;
    end
`endif
  end

  assign commit_s = (state_r != IDLE) && save_switch && !save_q_r;

  // Settings FSM: live time, shadow edit, commit, timeout and alarm slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      cur_min_r        <= {MIN_W{1'b0}};
      cur_hr_r         <= {HR_W{1'b0}};
      ed_min_r         <= {MIN_W{1'b0}};
      ed_hr_r          <= {HR_W{1'b0}};
      alarm_en_r       <= {NUM_ALARMS{1'b0}};
      sel_q_r          <= {SEL_W{1'b0}};
      idle_cnt_r       <= {CNT_W{1'b0}};
      save_q_r         <= 1'b0;
      set_alarm_r      <= 1'b0;
      timeout_revert_r <= 1'b0;
      editing_r        <= 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alarm_min_r[i] <= {MIN_W{1'b0}};
        alarm_hr_r[i]  <= {HR_W{1'b0}};
      end
    end else begin
      set_alarm_r      <= 1'b0;
      timeout_revert_r <= 1'b0;
      save_q_r         <= save_switch;
      if (tick_minute) begin
        cur_min_r <= live_min_next_s;
        cur_hr_r  <= live_hr_next_s;
      end
      case (state_r)
        IDLE: begin
          if (time_mode_switch) begin
            state_r    <= EDIT_TIME;
            editing_r  <= 1'b1;
            ed_min_r   <= cur_min_r;
            ed_hr_r    <= cur_hr_r;
            idle_cnt_r <= {CNT_W{1'b0}};
          end else if (alarm_mode_switch) begin
            state_r    <= EDIT_ALARM;
            editing_r  <= 1'b1;
            sel_q_r    <= alarm_sel;
            ed_min_r   <= alarm_min_r[alarm_sel];
            ed_hr_r    <= alarm_hr_r[alarm_sel];
            idle_cnt_r <= {CNT_W{1'b0}};
          end else begin
            state_r   <= IDLE;
            editing_r <= 1'b0;
          end
        end
        EDIT_TIME, EDIT_ALARM: begin
          if (!still_editing_s) begin
            // Leaving without a save throws the shadow away.
            state_r   <= IDLE;
            editing_r <= 1'b0;
          end else if (commit_s) begin
            // Commit uses the shadow as it stood; a same-cycle press is lost.
            if (state_r == EDIT_TIME) begin
              cur_min_r <= ed_min_r;
              cur_hr_r  <= ed_hr_r;
            end else begin
              alarm_min_r[sel_q_r] <= ed_min_r;
              alarm_hr_r[sel_q_r]  <= ed_hr_r;
              alarm_en_r[sel_q_r]  <= 1'b1;
              set_alarm_r          <= 1'b1;
            end
            idle_cnt_r <= {CNT_W{1'b0}};
          end else if (press_s) begin
            ed_min_r   <= min_step_s;
            ed_hr_r    <= hr_step_s;
            idle_cnt_r <= {CNT_W{1'b0}};
`ifdef ALARM_DISABLE_EN
            if ((state_r == EDIT_ALARM) && alarm_disable_btn) begin
              alarm_en_r[sel_q_r] <= 1'b0;
            end
`endif
          end else if (tick_second) begin
            if (idle_cnt_r == CNT_W'(TIMEOUT_TICKS - 1)) begin
              ed_min_r         <= committed_min_s;
              ed_hr_r          <= committed_hr_s;
              timeout_revert_r <= 1'b1;
              idle_cnt_r       <= {CNT_W{1'b0}};
            end else begin
              idle_cnt_r <= idle_cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          editing_r <= 1'b0;
        end
      endcase
    end
  end

  assign current_minutes = cur_min_r;
  assign current_hours   = cur_hr_r;
  assign edit_minutes    = ed_min_r;
  assign edit_hours      = ed_hr_r;
  assign alarm_enable    = alarm_en_r;
  assign set_alarm       = set_alarm_r;
  assign editing         = editing_r;
  assign timeout_revert  = timeout_revert_r;

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_flat
    assign alarm_minutes_flat[i*MIN_W +: MIN_W] = alarm_min_r[i];
    assign alarm_hours_flat[i*HR_W +: HR_W]     = alarm_hr_r[i];
  end

endmodule

// File: tb/tb_time_settings_ctrl.sv
// Directed bench for time_settings_ctrl with a minute-count reference model
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_time_settings_ctrl;

  localparam int NA    = 4;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;
  localparam int TO    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_second = 1'b0, tick_minute = 1'b0;
  logic time_mode_switch = 1'b0, alarm_mode_switch = 1'b0, save_switch = 1'b0;
  logic [1:0] alarm_sel = 2'd0;
  logic digit_sel = 1'b0;
  logic inc_min_btn = 1'b0, dec_min_btn = 1'b0, inc_hour_btn = 1'b0, dec_hour_btn = 1'b0;
`ifdef ALARM_DISABLE_EN
  logic alarm_disable_btn = 1'b0;
`endif
  logic [MIN_W-1:0]    current_minutes, edit_minutes;
  logic [HR_W-1:0]     current_hours, edit_hours;
  logic [NA*MIN_W-1:0] alarm_minutes_flat;
  logic [NA*HR_W-1:0]  alarm_hours_flat;
  logic [NA-1:0]       alarm_enable;
  logic                set_alarm, editing, timeout_revert;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int n_set = 0;
  int n_to  = 0;

  // Reference model state: live time held as minutes since midnight.
  int m_live, m_ed_min, m_ed_hr, m_mode, m_sel, m_idle;
  int m_al_min [NA];
  int m_al_hr  [NA];
  bit [NA-1:0] m_en;
  bit m_save_q, m_set, m_to;

  time_settings_ctrl dut (
    .clk(clk), .rst(rst), .tick_second(tick_second), .tick_minute(tick_minute),
    .time_mode_switch(time_mode_switch), .alarm_mode_switch(alarm_mode_switch),
    .save_switch(save_switch), .alarm_sel(alarm_sel), .digit_sel(digit_sel),
    .inc_min_btn(inc_min_btn), .dec_min_btn(dec_min_btn),
    .inc_hour_btn(inc_hour_btn), .dec_hour_btn(dec_hour_btn),
`ifdef ALARM_DISABLE_EN
    .alarm_disable_btn(alarm_disable_btn),
`endif
    .current_minutes(current_minutes), .current_hours(current_hours),
    .edit_minutes(edit_minutes), .edit_hours(edit_hours),
    .alarm_minutes_flat(alarm_minutes_flat), .alarm_hours_flat(alarm_hours_flat),
    .alarm_enable(alarm_enable), .set_alarm(set_alarm), .editing(editing),
    .timeout_revert(timeout_revert)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int stepf(input int v, input int m, input bit inc, input bit dec, input bit tens);
    if (inc == dec) return v;
    if (inc) return tens ? ((v + 10 < m) ? v + 10 : v) : ((v + 1) % m);
    return tens ? ((v >= 10) ? v - 10 : v) : ((v + m - 1) % m);
  endfunction

  // Reference model, advanced on every active edge from the same inputs.
  always @(posedge clk) begin
    int  live_old;
    bit  commit, press, sw;
    if (rst) begin
      m_live = 0; m_ed_min = 0; m_ed_hr = 0; m_mode = 0; m_sel = 0; m_idle = 0;
      m_en = '0; m_save_q = 1'b0; m_set = 1'b0; m_to = 1'b0;
      for (int i = 0; i < NA; i++) begin m_al_min[i] = 0; m_al_hr[i] = 0; end
    end else begin
      live_old = m_live;
      commit   = (m_mode != 0) && save_switch && !m_save_q;
      press    = inc_min_btn || dec_min_btn || inc_hour_btn || dec_hour_btn;
      m_set = 1'b0; m_to = 1'b0;
      if (tick_minute) m_live = (m_live + 1) % (60 * 24);
      if (m_mode == 0) begin
        if (time_mode_switch) begin
          m_mode = 1; m_ed_min = live_old % 60; m_ed_hr = live_old / 60; m_idle = 0;
        end else if (alarm_mode_switch) begin
          m_mode = 2; m_sel = int'(alarm_sel);
          m_ed_min = m_al_min[m_sel]; m_ed_hr = m_al_hr[m_sel]; m_idle = 0;
        end
      end else begin
        sw = (m_mode == 1) ? time_mode_switch : alarm_mode_switch;
        if (!sw) m_mode = 0;
        else if (commit) begin
          if (m_mode == 1) m_live = m_ed_hr * 60 + m_ed_min;
          else begin
            m_al_min[m_sel] = m_ed_min; m_al_hr[m_sel] = m_ed_hr;
            m_en[m_sel] = 1'b1; m_set = 1'b1;
          end
          m_idle = 0;
        end else if (press) begin
          m_ed_min = stepf(m_ed_min, 60, inc_min_btn, dec_min_btn, digit_sel);
          m_ed_hr  = stepf(m_ed_hr, 24, inc_hour_btn, dec_hour_btn, digit_sel);
          m_idle = 0;
        end else if (tick_second) begin
          m_idle++;
          if (m_idle == TO) begin
            if (m_mode == 1) begin m_ed_min = live_old % 60; m_ed_hr = live_old / 60; end
            else begin m_ed_min = m_al_min[m_sel]; m_ed_hr = m_al_hr[m_sel]; end
            m_to = 1'b1; m_idle = 0;
          end
        end
      end
      m_save_q = save_switch;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    logic [NA*MIN_W-1:0] exp_min_flat;
    logic [NA*HR_W-1:0]  exp_hr_flat;
    if (chk_en) begin
      for (int i = 0; i < NA; i++) begin
        exp_min_flat[i*MIN_W +: MIN_W] = MIN_W'(m_al_min[i]);
        exp_hr_flat[i*HR_W +: HR_W]    = HR_W'(m_al_hr[i]);
      end
      chk("current_minutes", int'(current_minutes), m_live % 60);
      chk("current_hours", int'(current_hours), m_live / 60);
      chk("edit_minutes", int'(edit_minutes), m_ed_min);
      chk("edit_hours", int'(edit_hours), m_ed_hr);
      chk("alarm_minutes_flat", int'(alarm_minutes_flat), int'(exp_min_flat));
      chk("alarm_hours_flat", int'(alarm_hours_flat), int'(exp_hr_flat));
      chk("alarm_enable", int'(alarm_enable), int'(m_en));
      chk("set_alarm", int'(set_alarm), int'(m_set));
      chk("editing", int'(editing), (m_mode != 0) ? 1 : 0);
      chk("timeout_revert", int'(timeout_revert), int'(m_to));
      if (set_alarm) n_set++;
      if (timeout_revert) n_to++;
    end
  end

  // One clock period; single-cycle pulse inputs are released afterwards.
  task automatic cyc();
    @(negedge clk);
    tick_second = 1'b0; tick_minute = 1'b0;
    inc_min_btn = 1'b0; dec_min_btn = 1'b0; inc_hour_btn = 1'b0; dec_hour_btn = 1'b0;
  endtask

  initial begin
    // Reset and minute counting with carry into hours.
    rst = 1'b1; cyc(); chk_en = 1'b1; cyc(); rst = 1'b0;
    chk("reset current_minutes", int'(current_minutes), 0);
    chk("reset editing", int'(editing), 0);
    repeat (61) begin tick_minute = 1'b1; cyc(); end
    chk("61 ticks minutes", int'(current_minutes), 1);
    chk("61 ticks hours", int'(current_hours), 1);
    chk("61 ticks alarm_enable", int'(alarm_enable), 0);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("re-reset hours", int'(current_hours), 0);

    // Edit live time: unit wrap down on minutes, saturating tens on hours.
    time_mode_switch = 1'b1; cyc();
    chk("enter editing", int'(editing), 1);
    digit_sel = 1'b0; dec_min_btn = 1'b1; cyc();
    chk("dec_min wrap", int'(edit_minutes), 59);
    digit_sel = 1'b1;
    inc_hour_btn = 1'b1; cyc();
    inc_hour_btn = 1'b1; cyc();
    chk("tens hour x2", int'(edit_hours), 20);
    inc_hour_btn = 1'b1; cyc();
    chk("tens hour saturate", int'(edit_hours), 20);
    digit_sel = 1'b0;
    save_switch = 1'b1; cyc();
    chk("commit minutes", int'(current_minutes), 59);
    chk("commit hours", int'(current_hours), 20);
    time_mode_switch = 1'b0; save_switch = 1'b0; cyc();
    chk("leave editing", int'(editing), 0);

    // Edit alarm slot 2 to 07:00 and arm it.
    alarm_sel = 2'd2; alarm_mode_switch = 1'b1; cyc();
    repeat (7) begin inc_hour_btn = 1'b1; cyc(); end
    chk("alarm shadow hours", int'(edit_hours), 7);
    save_switch = 1'b1; cyc();
    chk("set_alarm pulse", int'(set_alarm), 1);
    chk("slot2 hours", int'((alarm_hours_flat >> (2 * HR_W)) & 24'h1f), 7);
    chk("slot2 minutes", int'((alarm_minutes_flat >> (2 * MIN_W)) & 24'h3f), 0);
    chk("alarm_enable slot2", int'(alarm_enable), 4);
    alarm_mode_switch = 1'b0; save_switch = 1'b0; cyc(); cyc();
    chk("set_alarm once", n_set, 1);

    // Idle timeout reverts the shadow to the live time.
    time_mode_switch = 1'b1; cyc();
    inc_min_btn = 1'b1; cyc();
    chk("inc_min wrap no carry", int'(edit_minutes), 0);
    chk("inc_min hours kept", int'(edit_hours), 20);
    repeat (TO) begin tick_second = 1'b1; cyc(); cyc(); end
    chk("timeout once", n_to, 1);
    chk("reverted minutes", int'(edit_minutes), 59);
    chk("live unchanged", int'(current_minutes), 59);

    // Cancelling presses; press plus commit and tick in one cycle.
    inc_min_btn = 1'b1; dec_min_btn = 1'b1; cyc();
    chk("inc+dec cancel", int'(edit_minutes), 59);
    inc_min_btn = 1'b1; cyc();
    inc_min_btn = 1'b1; save_switch = 1'b1; tick_minute = 1'b1; cyc();
    chk("commit excludes press", int'(current_minutes), 0);
    chk("commit overrides tick", int'(current_hours), 20);
    chk("press dropped", int'(edit_minutes), 0);

    // Reset in the middle of an edit.
    inc_hour_btn = 1'b1; cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid-edit reset editing", int'(editing), 0);
    chk("mid-edit reset hours", int'(current_hours), 0);
    chk("mid-edit reset shadow", int'(edit_hours), 0);
    chk("mid-edit reset enable", int'(alarm_enable), 0);
    time_mode_switch = 1'b0; save_switch = 1'b0; cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
